// File: rtl/codec_cfg_pkg.sv
// Shared types and the default WM8731 power-up table for the codec configuration sequencer.
// Table words are {7-bit register address, 9-bit data}; entry 0 sits in the least significant 16 bits.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEV,
        S_HI,
        S_LO,
        S_STOP,
        S_GAP,
        S_DONE,
        S_ERR
    } cfg_state_e;

    localparam logic [6:0] R_LLINE   = 7'h00;
    localparam logic [6:0] R_RLINE   = 7'h01;
    localparam logic [6:0] R_LHP     = 7'h02;
    localparam logic [6:0] R_RHP     = 7'h03;
    localparam logic [6:0] R_APATH   = 7'h04;
    localparam logic [6:0] R_DPATH   = 7'h05;
    localparam logic [6:0] R_PWR     = 7'h06;
    localparam logic [6:0] R_FORMAT  = 7'h07;
    localparam logic [6:0] R_SRATE   = 7'h08;
    localparam logic [6:0] R_ACTIVE  = 7'h09;
    localparam logic [6:0] R_RESET   = 7'h0F;

    localparam int TABLE_DEPTH = 64;

    function automatic logic [15:0] wm_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

    // Outputs stay powered down until the last power write so the DAC comes up without a pop.
    localparam logic [TABLE_DEPTH*16-1:0] DEFAULT_TABLE = {
        {((TABLE_DEPTH - 10) * 16){1'b0}},
        wm_word(R_ACTIVE, 9'h001),
        wm_word(R_PWR,    9'h000),
        wm_word(R_SRATE,  9'h000),
        wm_word(R_FORMAT, 9'h002),
        wm_word(R_DPATH,  9'h000),
        wm_word(R_APATH,  9'h012),
        wm_word(R_LHP,    9'h179),
        wm_word(R_LLINE,  9'h117),
        wm_word(R_PWR,    9'h010),
        wm_word(R_RESET,  9'h000)
    };

endpackage

// File: rtl/codec_cfg_if.sv
// Command/completion link between the configuration sequencer and the I2C host.
// Valid/ready: a one-cycle command pulse is accepted by the host, which answers with one i2c_done pulse
// (i2c_ack valid only then); no new command until the cycle after i2c_done, wr_data held meanwhile.
interface codec_cfg_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic       i2c_write;
    logic       i2c_read;
    logic [7:0] i2c_wr_data;
    logic       i2c_done;
    logic       i2c_ack;

    modport master (
        output i2c_start, i2c_stop, i2c_write, i2c_read, i2c_wr_data,
        input  i2c_done, i2c_ack
    );

    modport slave (
        input  i2c_start, i2c_stop, i2c_write, i2c_read, i2c_wr_data,
        output i2c_done, i2c_ack
    );
endinterface

// File: rtl/codec_init_rom.sv
// Combinational lookup of one 16-bit codec register word by table index.
module codec_init_rom
    import codec_cfg_pkg::*;
#(
    parameter int                          N_REGS = 10,
    parameter logic [TABLE_DEPTH*16-1:0]   TABLE  = DEFAULT_TABLE
) (
    input  logic [5:0]  idx,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        if (int'(idx) < N_REGS) begin
            word = TABLE[{idx, 4'b0000} +: 16];
        end
    end

endmodule

// File: rtl/codec_cfg_seq.sv
// Power-up sequencer: writes each table word to the codec as START, address, high byte, low byte, STOP,
// retrying NACKed entries and reporting done/error levels to the top level.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]                DEV_ADDR   = 7'h1A,
    parameter int                        N_REGS     = 10,
    parameter int                        MAX_RETRY  = 3,
    parameter int                        GAP_CYCLES = 2000,
    parameter logic [TABLE_DEPTH*16-1:0] TABLE      = DEFAULT_TABLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [5:0]        err_idx,
    codec_cfg_if.master       bus,
    output cfg_state_e        dbg_state
);

    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [5:0]         LAST_IDX  = 6'(N_REGS - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    cfg_state_e         state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               fail_q, fail_d;
    logic               wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [5:0]         err_idx_q, err_idx_d;
    logic [15:0]        rom_word;
    logic               cmd_state;

    codec_init_rom #(
        .N_REGS (N_REGS),
        .TABLE  (TABLE)
    ) u_rom (
        .idx  (idx_q),
        .word (rom_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            fail_q    <= 1'b0;
            wait_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            fail_q    <= fail_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign cmd_state = (state_q == S_START) || (state_q == S_DEV) || (state_q == S_HI) ||
                       (state_q == S_LO)    || (state_q == S_STOP);

    // Command pulses fire only in the first cycle of a command state; wait_q marks the rest.
    always_comb begin
        bus.i2c_start   = (state_q == S_START) && !wait_q;
        bus.i2c_stop    = (state_q == S_STOP)  && !wait_q;
        bus.i2c_write   = ((state_q == S_DEV) || (state_q == S_HI) || (state_q == S_LO)) && !wait_q;
        bus.i2c_read    = 1'b0;
        bus.i2c_wr_data = 8'h00;
        case (state_q)
            S_DEV:   bus.i2c_wr_data = {DEV_ADDR, 1'b0};
            S_HI:    bus.i2c_wr_data = rom_word[15:8];
            S_LO:    bus.i2c_wr_data = rom_word[7:0];
            default: bus.i2c_wr_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        fail_d    = fail_q;
        wait_d    = wait_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    state_d   = S_START;
                    idx_d     = '0;
                    retry_d   = '0;
                    fail_d    = 1'b0;
                    wait_d    = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (!fail_q) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_q + 6'd1;
                        retry_d = '0;
                    end
                end else if (retry_q != RETRY_MAX) begin
                    state_d = S_START;
                    retry_d = retry_q + 1'b1;
                    fail_d  = 1'b0;
                end else begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                if (cmd_state) begin
                    if (!wait_q) begin
                        wait_d = 1'b1;
                    end else if (bus.i2c_done) begin
                        wait_d = 1'b0;
                        case (state_q)
                            S_START: state_d = S_DEV;
                            S_DEV:   state_d = bus.i2c_ack ? S_HI : S_STOP;
                            S_HI:    state_d = bus.i2c_ack ? S_LO : S_STOP;
                            S_LO:    state_d = S_STOP;
                            default: begin
                                state_d = S_GAP;
                                gap_d   = GAP_LOAD;
                            end
                        endcase
                        // A NACK on any byte skips the rest of the entry and marks it for retry.
                        if (((state_q == S_DEV) || (state_q == S_HI) || (state_q == S_LO)) && !bus.i2c_ack) begin
                            fail_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_idx   = err_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq: a responding I2C host model, a bus-event scoreboard and handshake checks.
module tb_codec_cfg_seq;
    import codec_cfg_pkg::*;

    localparam int GAP  = 4;
    localparam int NREG = 2;
    localparam int MAXR = 3;
    localparam logic [TABLE_DEPTH*16-1:0] TB_TABLE = {{((TABLE_DEPTH - 2) * 16){1'b0}}, 16'h1201, 16'h1E00};

    localparam logic [2:0] EV_START = 3'd1;
    localparam logic [2:0] EV_STOP  = 3'd2;
    localparam logic [2:0] EV_WRITE = 3'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       cfg_busy, cfg_done, cfg_err;
    logic [5:0] err_idx;
    cfg_state_e dbg_state;

    codec_cfg_if bus_if();

    codec_cfg_seq #(
        .DEV_ADDR   (7'h1A),
        .N_REGS     (NREG),
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (GAP),
        .TABLE      (TB_TABLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_idx   (err_idx),
        .bus       (bus_if.master),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_q[$];
    int cyc = 0;
    int write_cnt = 0;
    int cmd_cnt = 0;
    int start_seen = 0;
    int start_base = 0;
    int nack_mode = 0;
    bit pending = 1'b0;
    logic [2:0] pend_type = 3'd0;
    logic [7:0] wr_hold = 8'h00;
    bit stop_valid = 1'b0;
    int stop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [2:0] t, input logic [7:0] d);
        exp_q.push_back({t, d});
    endtask

    task automatic push_ok(input logic [15:0] w);
        push_ev(EV_START, 8'h00);
        push_ev(EV_WRITE, 8'h34);
        push_ev(EV_WRITE, w[15:8]);
        push_ev(EV_WRITE, w[7:0]);
        push_ev(EV_STOP, 8'h00);
    endtask

    task automatic push_nack_addr();
        push_ev(EV_START, 8'h00);
        push_ev(EV_WRITE, 8'h34);
        push_ev(EV_STOP, 8'h00);
    endtask

    task automatic pulse_go();
        start_base = start_seen;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (!(cfg_done || cfg_err)) begin
            fails++;
            $display("FAIL %s: run did not finish within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_state(input cfg_state_e s, input string name, input int budget);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (dbg_state != s) begin
            fails++;
            $display("FAIL %s: state %0d not reached, got %0d", name, s, dbg_state);
        end
    endtask

    // Host model NACK policy, keyed on the START count within the current run.
    function automatic logic slave_ack(input bit is_wr, input logic [7:0] d);
        int n = start_seen - start_base;
        if (!is_wr || d != 8'h34) return 1'b1;
        if (nack_mode == 1 && n == 1) return 1'b0;
        if (nack_mode == 2 && n >= 2) return 1'b0;
        return 1'b1;
    endfunction

    // driver: I2C host model answering each command two cycles later
    initial begin : host_model
        bit is_wr;
        logic [7:0] d;
        bus_if.i2c_done = 1'b0;
        bus_if.i2c_ack  = 1'b0;
        forever begin
            tick();
            while (rst_n && (bus_if.i2c_start || bus_if.i2c_stop || bus_if.i2c_write)) begin
                is_wr = bus_if.i2c_write;
                d     = bus_if.i2c_wr_data;
                if (bus_if.i2c_start) start_seen++;
                repeat (2) tick();
                bus_if.i2c_done = 1'b1;
                bus_if.i2c_ack  = slave_ack(is_wr, d);
                tick();
                bus_if.i2c_done = 1'b0;
                bus_if.i2c_ack  = 1'b0;
            end
        end
    end

    // scoreboard monitor and handshake checker
    always @(negedge clk) begin : monitor
        logic [10:0] ev;
        logic [10:0] want;
        logic [2:0]  ty;
        int          ncmd;
        bit          done_now;
        cyc++;
        if (go) stop_valid = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            ncmd = int'(bus_if.i2c_start) + int'(bus_if.i2c_stop) + int'(bus_if.i2c_write) + int'(bus_if.i2c_read);
            done_now = bus_if.i2c_done && pending;
            if (done_now) begin
                if (pend_type == EV_STOP) begin
                    stop_valid = 1'b1;
                    stop_cyc   = cyc;
                end
                pending = 1'b0;
            end
            if (ncmd != 0) begin
                cmd_cnt++;
                tests++;
                if (ncmd > 1 || bus_if.i2c_read || pending || done_now) begin
                    fails++;
                    $display("FAIL handshake: cmds=%0d read=%0b pending=%0b done_same_cycle=%0b required 1/0/0/0",
                             ncmd, bus_if.i2c_read, pending, done_now);
                end
                ty = bus_if.i2c_start ? EV_START : (bus_if.i2c_stop ? EV_STOP : EV_WRITE);
                ev = {ty, (ty == EV_WRITE) ? bus_if.i2c_wr_data : 8'h00};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_seq: got event %03h, required none", ev);
                end else begin
                    want = exp_q.pop_front();
                    if (ev !== want) begin
                        fails++;
                        $display("FAIL bus_seq: got event %03h, required %03h", ev, want);
                    end
                end
                if (ty == EV_WRITE) begin
                    wr_hold = bus_if.i2c_wr_data;
                    write_cnt++;
                end
                if (ty == EV_START && stop_valid) begin
                    tests++;
                    if (cyc - stop_cyc != GAP + 1) begin
                        fails++;
                        $display("FAIL gap: got %0d idle cycles, required %0d", cyc - stop_cyc - 1, GAP);
                    end
                    stop_valid = 1'b0;
                end
                pending   = 1'b1;
                pend_type = ty;
            end else if (pending && pend_type == EV_WRITE) begin
                tests++;
                if (bus_if.i2c_wr_data !== wr_hold) begin
                    fails++;
                    $display("FAIL wr_data_stable: got %02h required %02h", bus_if.i2c_wr_data, wr_hold);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(cfg_busy), 0);
        check("rst_done", 32'(cfg_done), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        check("rst_cmds", 32'({bus_if.i2c_start, bus_if.i2c_stop, bus_if.i2c_write, bus_if.i2c_read}), 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        repeat (2) tick();

        // normal run, all ACKed
        nack_mode = 0;
        push_ok(16'h1E00);
        push_ok(16'h1201);
        pulse_go();
        check("go_busy", 32'(cfg_busy), 1);
        wait_end("run_normal", 400);
        check("normal_done", 32'(cfg_done), 1);
        check("normal_busy", 32'(cfg_busy), 0);
        check("normal_err", 32'(cfg_err), 0);
        check("normal_queue", 32'(exp_q.size()), 0);

        // first address byte NACKed, entry 0 retried
        nack_mode = 1;
        base = write_cnt;
        push_nack_addr();
        push_ok(16'h1E00);
        push_ok(16'h1201);
        pulse_go();
        check("nack1_done_cleared", 32'(cfg_done), 0);
        wait_end("run_nack1", 600);
        check("nack1_done", 32'(cfg_done), 1);
        check("nack1_err", 32'(cfg_err), 0);
        check("nack1_writes", 32'(write_cnt - base), 7);
        check("nack1_queue", 32'(exp_q.size()), 0);

        // entry 1 always NACKed: four attempts then error
        nack_mode = 2;
        push_ok(16'h1E00);
        repeat (MAXR + 1) push_nack_addr();
        pulse_go();
        wait_end("run_nack_all", 800);
        check("err_flag", 32'(cfg_err), 1);
        check("err_idx", 32'(err_idx), 1);
        check("err_done", 32'(cfg_done), 0);
        check("err_busy", 32'(cfg_busy), 0);
        check("err_state", 32'(dbg_state), 32'(S_ERR));
        base = cmd_cnt;
        repeat (40) tick();
        check("err_no_cmds", 32'(cmd_cnt - base), 0);
        check("err_queue", 32'(exp_q.size()), 0);

        // restart after error; go during S_HI is ignored
        nack_mode = 0;
        push_ok(16'h1E00);
        push_ok(16'h1201);
        pulse_go();
        check("restart_err_clear", 32'(cfg_err), 0);
        check("restart_err_idx", 32'(err_idx), 0);
        check("restart_busy", 32'(cfg_busy), 1);
        wait_state(S_HI, "reach_hi", 100);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("midrun_busy", 32'(cfg_busy), 1);
        wait_end("run_restart", 600);
        check("restart_done", 32'(cfg_done), 1);
        check("restart_queue", 32'(exp_q.size()), 0);

        // reset while waiting in S_LO
        push_ev(EV_START, 8'h00);
        push_ev(EV_WRITE, 8'h34);
        push_ev(EV_WRITE, 8'h1E);
        push_ev(EV_WRITE, 8'h00);
        pulse_go();
        wait_state(S_LO, "reach_lo", 100);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(cfg_busy), 0);
        check("arst_done_err", 32'({cfg_done, cfg_err}), 0);
        check("arst_err_idx", 32'(err_idx), 0);
        check("arst_cmds", 32'({bus_if.i2c_start, bus_if.i2c_stop, bus_if.i2c_write, bus_if.i2c_read}), 0);
        check("arst_wr_data", 32'(bus_if.i2c_wr_data), 0);
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (10) tick();
        check("arst_queue", 32'(exp_q.size()), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        push_ok(16'h1E00);
        push_ok(16'h1201);
        pulse_go();
        wait_end("run_after_rst", 600);
        check("after_rst_done", 32'(cfg_done), 1);
        check("after_rst_queue", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/codec_cfg_seq.md
Name: codec_cfg_seq

Overview:
- Sequencer that drives `i2c_host` to write the audio codec's power-up register table after reset (WM8731-style: 7-bit register address plus 9-bit data, sent as two bytes).
- Walks a table of N_REGS 16-bit words. Each word is sent as one I2C transaction: START, device address with write bit, high byte, low byte, STOP.
- Retries a transaction on NACK and reports completion or error to the top level, which holds DAC streaming until `cfg_done`.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit I2C device address of the codec.
- N_REGS, 10, number of table entries (1..64).
- MAX_RETRY, 3, number of retries per entry after the first failed attempt.
- GAP_CYCLES, 2000, idle clk cycles after each STOP before the next START (bus free time; must be ≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse; starts or restarts the configuration run
- cfg_busy  out  1  high while a run is in progress
- cfg_done  out  1  level; all entries ACKed; cleared by the next accepted go
- cfg_err  out  1  level; retries exhausted; cleared by the next accepted go
- err_idx  out  6  table index that failed; valid while cfg_err=1
- i2c_start, i2c_stop, i2c_write, i2c_read  out  1 each  one-cycle command pulses to `i2c_host`; i2c_read is tied to 0
- i2c_wr_data  out  8  byte for i2c_write; held stable from the pulse until i2c_done
- i2c_done  in  1  one-cycle completion pulse from `i2c_host`
- i2c_ack  in  1  ACK of the last write; sampled only in the cycle i2c_done=1

Behaviour:
- Reset: all outputs 0, state S_IDLE, idx=0, retry=0, gap counter=0. Asynchronous assertion and deassertion at the flop level; the top level synchronises rst_n release.
- Reset mid-transaction:
  - Outputs go to 0 immediately.
  - The host is reset from the same source.
  - No STOP is generated; the bus recovers via the host reset.
- States: S_IDLE, S_START, S_DEV, S_HI, S_LO, S_STOP, S_GAP, S_DONE, S_ERR.
- Command states (S_START, S_DEV, S_HI, S_LO, S_STOP):
  - In the first cycle of the state, assert exactly one command pulse for one cycle.
  - Then wait for i2c_done.
  - The next command pulse is issued no earlier than the cycle after i2c_done.
  - Never assert two command pulses in the same cycle.
  - Never assert a command while waiting for i2c_done.
- Byte mapping per entry w = rom[idx]:
  - S_DEV sends {DEV_ADDR, 1'b0}.
  - S_HI sends w[15:8].
  - S_LO sends w[7:0].
- Transitions:
  - S_IDLE/S_DONE/S_ERR + go → S_START; idx=0, retry=0; clear cfg_done, cfg_err, err_idx; set cfg_busy.
  - go while cfg_busy=1 is ignored.
  - S_START done → S_DEV.
  - S_DEV/S_HI done, ack=1 → next byte state.
  - S_LO done, ack=1 → S_STOP (entry OK).
  - Any write state done, ack=0 → S_STOP; remaining bytes are skipped and the entry is marked failed.
  - S_STOP done → S_GAP; counter loaded with GAP_CYCLES-1.
  - S_GAP counts down to 0, then:
    - Entry OK, idx<N_REGS-1 → idx+1, retry=0, S_START.
    - Entry OK, idx=N_REGS-1 → S_DONE; cfg_done=1, cfg_busy=0 in the same cycle.
    - Entry failed, retry<MAX_RETRY → retry+1, same idx, S_START.
    - Entry failed, retry=MAX_RETRY → S_ERR; cfg_err=1, err_idx=idx, cfg_busy=0.
- Attempts per entry total MAX_RETRY+1.
- i2c_done arriving in a non-waiting state is ignored (not expected).
- Widths:
  - idx: 6 bits; wrap is impossible since idx is bounded by N_REGS-1.
  - Gap counter: $clog2(GAP_CYCLES+1) bits.
  - retry: $clog2(MAX_RETRY+1) bits.

Decomposition:
- Package `codec_cfg_pkg`:
  - State enum.
  - WM8731 register address localparams.
  - Default init table (reset, power-down, analog path, digital path, format I2S 16-bit, sampling, active).
- Sub-module `codec_init_rom`:
  - Combinational idx → 16-bit word lookup from the package table.
  - Keeps table edits out of the FSM.

Test Plan:
- Normal run: N_REGS=2, rom={16'h1E00, 16'h1201}, slave ACKs all, go. Required bus sequence:
  - START, 34, 1E, 00, STOP.
  - GAP_CYCLES idle.
  - START, 34, 12, 01, STOP.
  - Then cfg_done=1, cfg_busy=0, cfg_err=0.
- Single NACK: slave NACKs the first 0x34 only. Required:
  - STOP right after the address byte, then a full retry of entry 0.
  - Run completes with cfg_done=1.
  - Exactly 6 writes plus the 1 failed write observed.
- Persistent NACK on entry 1 (MAX_RETRY=3): exactly 4 attempts on entry 1, then cfg_err=1, err_idx=1, cfg_done=0, no further commands.
- Handshake checker over all runs:
  - At most one command pulse per cycle.
  - No command between a pulse and its i2c_done.
  - i2c_wr_data stable during each write.
  - i2c_read never asserted.
- go pulsed mid-run (during S_HI) is ignored. go pulsed after S_ERR restarts from idx 0 and clears cfg_err in the cycle after the go.
- rst_n asserted during S_LO: all outputs are 0 asynchronously. After release and go, entry 0 is resent from START.
